// File: rtl/alu_result_stage.sv
// Registered result stage behind the 64-bit adder: optional saturation, NZCV flags,
// overflow statistics and a 2-entry valid/ready buffer with a registered in_ready.
module alu_result_stage #(
  parameter int WIDTH    = 64,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_stats
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_data;
  logic [3:0]       skid_flags;
  logic [WIDTH-1:0] proc_data;
  logic [3:0]       proc_flags;
  logic [WIDTH-1:0] sat_max;
  logic [WIDTH-1:0] sat_min;
  logic             accept;
  logic             drain;

  assign sat_max = {1'b0, {(WIDTH-1){1'b1}}};
  assign sat_min = {1'b1, {(WIDTH-1){1'b0}}};
  assign accept  = in_valid & in_ready;
  assign drain   = out_valid & out_ready;

  // A wrapped-negative sum means the true result overflowed positively, and vice versa.
  always_comb begin
    proc_data = in_sum;
    if ((SATURATE != 0) && in_ovf)
      proc_data = in_sum[WIDTH-1] ? sat_max : sat_min;
    proc_flags = {proc_data[WIDTH-1], (proc_data == '0), in_carry, in_ovf};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      out_data   <= '0;
      out_flags  <= '0;
      skid_data  <= '0;
      skid_flags <= '0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= proc_data;
            out_flags <= proc_flags;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_data  <= proc_data;
            out_flags <= proc_flags;
          end else if (accept) begin
            // Output is stalled: park the new entry and stop accepting next cycle.
            skid_data  <= proc_data;
            skid_flags <= proc_flags;
            in_ready   <= 1'b0;
            state      <= TWO;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            out_data  <= skid_data;
            out_flags <= skid_flags;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase

      if (clr_stats) begin
        ovf_sticky <= 1'b0;
        ovf_count  <= '0;
      end else if (accept && in_ovf) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != {CNT_W{1'b1}})
          ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
